// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic units: FSM state encoding and default width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first, one bit per clock,
// through a single full_subtractor cell and a borrow flop.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE accepts a new start just like IDLE so back-to-back operation loses no cycle.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_load) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
        end else if (w_shift) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_bin    <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
            // Outputs only move on the final bit, so shift activity never leaks out.
            if (w_last) begin
                r_diff   <= w_res_next;
                r_borrow <= w_bout;
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 plus an all-pairs sweep at WIDTH=4.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    logic         start4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         busy4;
    logic         done4;
    logic [3:0]   diff4;
    logic         borrow4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One start pulse, then watch busy/diff until done (bounded).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ediff, input logic eb, input string tag);
        int           busy_cnt;
        int           lat;
        logic         seen;
        logic         stable;
        logic [W-1:0] d0;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = diff; stable = 1'b1; busy_cnt = 0; lat = 0; seen = 1'b0;
        for (int i = 1; i <= W + 4 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (busy) busy_cnt++;
                if (diff !== d0) stable = 1'b0;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_diff_stable"}, stable, 1);
        check({tag, "_diff"}, diff, ediff);
        check({tag, "_borrow"}, borrow, eb);
        @(negedge clk);
        check({tag, "_done_single"}, done, 0);
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!busy && !done) idle = 1'b1;
        end
        check({tag, "_idle"}, idle, 1);
    endtask

    initial begin
        int           last;
        int           pulses;
        logic         prev_done;
        logic         seen;
        logic         stable;
        logic [W-1:0] d0;
        int           idx;
        int           ea;
        int           eb4;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_w4_diff", diff4, 0);
        rst_n = 1'b1;

        run_op(8'd10, 8'd3, 8'd7, 1'b0, "sub10_3");
        run_op(8'd0, 8'd1, 8'hFF, 1'b1, "sub0_1");
        run_op(8'h80, 8'h80, 8'h00, 1'b0, "sub80_80");

        // start held high: a result every W+1 cycles, never adjacent done.
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        last = -1; pulses = 0; prev_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held_diff", diff, 100);
                check("held_borrow", borrow, 0);
                check("held_not_adjacent", prev_done, 0);
                if (last >= 0) check("held_period", i - last, W + 1);
                last = i;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("held_pulses", pulses, 4);
        wait_idle("held");

        // Start during RUN with new operands must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; d0 = diff; stable = 1'b1;
        @(negedge clk);
        if (diff !== d0) stable = 1'b0;
        @(negedge clk);
        a = 8'd50; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        seen = 1'b0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (diff !== d0) stable = 1'b0;
                @(negedge clk);
            end
        end
        check("ignore_done_seen", seen, 1);
        check("ignore_diff_stable", stable, 1);
        check("ignore_diff", diff, 7);
        check("ignore_borrow", borrow, 0);
        wait_idle("ignore");

        // Reset mid-RUN aborts and clears outputs immediately.
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", done, 0);
        rst_n = 1'b1;
        run_op(8'd5, 8'd9, 8'hFC, 1'b1, "after_rst");

        // All 256 operand pairs at WIDTH=4 in a scrambled order.
        for (int i = 0; i < 256; i++) begin
            idx = (i * 37 + 11) % 256;
            ea  = idx / 16;
            eb4 = idx % 16;
            @(negedge clk);
            a4 = 4'(ea); b4 = 4'(eb4); start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 10 && !seen; j++) begin
                if (done4) seen = 1'b1;
                else @(negedge clk);
            end
            check("w4_done_seen", seen, 1);
            if (seen) begin
                check("w4_diff", diff4, (ea - eb4 + 16) % 16);
                check("w4_borrow", borrow4, (ea < eb4) ? 1 : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
